// File: rtl/slot_pkg.sv
// Shared constants for the slot-machine reel generator: FSM encoding, LFSR taps,
// reset state and per-reel salts that decorrelate reels fed from one seed.
package slot_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SPIN = 2'd1;
    localparam state_t ST_STOP = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_MASK   = 16'hB400;
    localparam logic [15:0] RESET_STATE = 16'hACE1;

    // No salt equals RESET_STATE, so no reel resets into the all-zero state
    localparam logic [7:0][15:0] SALT = {
        16'h2D71, 16'hC6E5, 16'h1B2D, 16'h7F4A,
        16'h9E37, 16'h3C96, 16'h5A5A, 16'h0000
    };

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slot_lfsr.sv
// One reel: Galois LFSR with seed load, step enable and a symbol filter that only
// accepts raw values inside the legal symbol range.
module slot_lfsr
    import slot_pkg::*;
#(
    parameter int                LFSR_W      = 16,
    parameter int                SEED_W      = 6,
    parameter int                SYM_W       = 4,
    parameter int                NUM_SYMBOLS = 10,
    parameter logic [LFSR_W-1:0] SALT_K      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              enable,
    input  logic [SEED_W-1:0] seed,
    output logic [SYM_W-1:0]  sym
);

    localparam logic [SYM_W:0] NUM_SYM_L = NUM_SYMBOLS[SYM_W:0];

    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] next_state;
    logic [LFSR_W-1:0] seed_exp;
    logic [LFSR_W-1:0] load_val;
    logic [SYM_W-1:0]  raw;

    for (genvar i = 0; i < LFSR_W; i++) begin : g_seed
        assign seed_exp[i] = seed[i % SEED_W];
    end

    always_comb begin
        load_val = seed_exp ^ SALT_K;
        // zero would lock the LFSR forever
        if (load_val == '0) begin
            load_val = {{(LFSR_W-1){1'b0}}, 1'b1};
        end
        next_state = {1'b0, state[LFSR_W-1:1]};
        if (state[0]) begin
            next_state = next_state ^ LFSR_MASK[LFSR_W-1:0];
        end
    end

    assign raw = next_state[SYM_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE[LFSR_W-1:0] ^ SALT_K;
            sym   <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (enable) begin
            state <= next_state;
            if ({1'b0, raw} < NUM_SYM_L) begin
                sym <= raw;
            end
        end
    end

endmodule

// File: rtl/slot_reel_rng.sv
// Multi-reel slot generator: per-reel LFSRs plus a spin/stop sequencer that freezes
// reels one after another and pulses result_valid once every reel has stopped.
module slot_reel_rng
    import slot_pkg::*;
#(
    parameter int N_REELS     = 3,
    parameter int LFSR_W      = 16,
    parameter int SEED_W      = 6,
    parameter int SYM_W       = 4,
    parameter int NUM_SYMBOLS = 10,
    parameter int MIN_SPIN    = 16,
    parameter int STOP_GAP    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEED_W-1:0]        seed_in,
    input  logic                     seed_load,
    input  logic                     spin_req,
    output logic                     busy,
    output logic [N_REELS*SYM_W-1:0] reel_sym,
    output logic [N_REELS-1:0]       reel_stopped,
    output logic                     result_valid
);

    localparam int LAST_STOP = MIN_SPIN + (N_REELS - 1) * STOP_GAP - 1;
    localparam int CNT_W     = cnt_width(LAST_STOP + 2);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [N_REELS-1:0] stop_now;
    logic               running;
    logic               load;

    assign running      = (state == ST_SPIN) || (state == ST_STOP);
    assign load         = (state == ST_IDLE) && seed_load;
    assign busy         = (state != ST_IDLE);

    // cnt holds (edges since acceptance - 1), so reel k freezes when it hits its slot
    for (genvar k = 0; k < N_REELS; k++) begin : g_reel
        assign stop_now[k] = running && (cnt == CNT_W'(MIN_SPIN - 1 + k * STOP_GAP));

        slot_lfsr #(
            .LFSR_W      (LFSR_W),
            .SEED_W      (SEED_W),
            .SYM_W       (SYM_W),
            .NUM_SYMBOLS (NUM_SYMBOLS),
            .SALT_K      (SALT[k][LFSR_W-1:0])
        ) u_lfsr (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load),
            .enable (!reel_stopped[k]),
            .seed   (seed_in),
            .sym    (reel_sym[k*SYM_W +: SYM_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            reel_stopped <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (spin_req) begin
                        state        <= ST_SPIN;
                        cnt          <= '0;
                        reel_stopped <= '0;
                    end
                end
                ST_SPIN, ST_STOP: begin
                    cnt          <= cnt + 1'b1;
                    reel_stopped <= reel_stopped | stop_now;
                    if (stop_now[N_REELS-1]) begin
                        state <= ST_DONE;
                    end else if (stop_now[0]) begin
                        state <= ST_STOP;
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    result_valid <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
